// File: rtl/lsu_mem_ctrl.sv
// Load/store unit for the MEM stage: decodes the memory-control codes,
// aligns store data and byte strobes to the 64-bit bus, and extends load data.
// Misaligned or illegal requests fault locally, without any bus traffic.

// Byte-lane steering for one lane of the 64-bit bus.
module lsu_byte_lane #(
   parameter int LANE = 0
) (
   input  logic [2:0]  off,
   input  logic [7:0]  mask,
   input  logic [63:0] wdata,
   output logic        strb,
   output logic [7:0]  wbyte
);
   localparam logic [2:0] LIDX = 3'(LANE);

   logic [2:0] src;
   logic       hit;

   // Source byte is lane - offset; lanes below the offset receive nothing.
   assign src   = LIDX - off;
   assign hit   = (LIDX >= off);
   assign strb  = hit & mask[src];
   assign wbyte = hit ? wdata[{src, 3'b000} +: 8] : 8'h00;
endmodule

module lsu_mem_ctrl #(
   parameter int ADDR_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_rd_ctrl,
   input  logic [2:0]        req_wr_ctrl,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wstrb,
   output logic [63:0]       bus_wdata,
   input  logic              bus_rsp_valid,
   input  logic [63:0]       bus_rsp_rdata,
   input  logic              bus_rsp_err
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_M1 = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       rd_q;
   logic [2:0]       off_q;

   logic [2:0]       off;
   logic             rd_any;
   logic             wr_any;
   logic [7:0]       size_mask;
   logic             misal;
   logic             illegal;
   logic             fault;
   logic [7:0]       strb_c;
   logic [7:0][7:0]  wdata_lanes;
   logic [63:0]      rsp_sh;
   logic [63:0]      load_c;

   assign req_ready = (state == S_IDLE);
   assign off       = req_addr[2:0];
   assign rd_any    = |req_rd_ctrl;
   assign wr_any    = |req_wr_ctrl;

   // Decode access size, alignment and legality of the incoming request.
   always_comb begin
      size_mask = 8'h00;
      if (wr_any) begin
         case (req_wr_ctrl)
            3'b001:  size_mask = 8'h01;
            3'b010:  size_mask = 8'h03;
            3'b011:  size_mask = 8'h0F;
            3'b100:  size_mask = 8'hFF;
            default: size_mask = 8'h00;
         endcase
      end else begin
         case (req_rd_ctrl)
            3'b001, 3'b010: size_mask = 8'h01;
            3'b011, 3'b100: size_mask = 8'h03;
            3'b101:         size_mask = 8'h0F;
            3'b110:         size_mask = 8'hFF;
            default:        size_mask = 8'h00;
         endcase
      end
      case (size_mask)
         8'h03:   misal = off[0];
         8'h0F:   misal = |off[1:0];
         8'hFF:   misal = |off;
         default: misal = 1'b0;
      endcase
      illegal = (req_rd_ctrl == 3'b111) || (req_wr_ctrl >= 3'b101);
      fault   = illegal || (rd_any && wr_any) || misal;
   end

   // One steering instance per bus byte lane.
   for (genvar g = 0; g < 8; g++) begin : g_lane
      lsu_byte_lane #(.LANE(g)) u_lane (
         .off   (off),
         .mask  (size_mask),
         .wdata (req_wdata),
         .strb  (strb_c[g]),
         .wbyte (wdata_lanes[g])
      );
   end

   // Pull the addressed field down to bit 0 and extend by load type.
   always_comb begin
      rsp_sh = bus_rsp_rdata >> {off_q, 3'b000};
      case (rd_q)
         3'b001:  load_c = {{56{rsp_sh[7]}},  rsp_sh[7:0]};
         3'b010:  load_c = {56'h0,            rsp_sh[7:0]};
         3'b011:  load_c = {{48{rsp_sh[15]}}, rsp_sh[15:0]};
         3'b100:  load_c = {48'h0,            rsp_sh[15:0]};
         3'b101:  load_c = {{32{rsp_sh[31]}}, rsp_sh[31:0]};
         3'b110:  load_c = bus_rsp_rdata;
         default: load_c = 64'h0;
      endcase
   end

   // Transaction FSM; all outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         rd_q          <= 3'b000;
         off_q         <= 3'b000;
         resp_valid    <= 1'b0;
         resp_rdata    <= 64'h0;
         resp_err      <= 1'b0;
         bus_req_valid <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_wstrb     <= 8'h00;
         bus_wdata     <= 64'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  rd_q  <= req_rd_ctrl;
                  off_q <= off;
                  if (fault || !(rd_any || wr_any)) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= fault;
                     resp_rdata <= 64'h0;
                  end else begin
                     state         <= S_REQ;
                     bus_req_valid <= 1'b1;
                     bus_we        <= wr_any;
                     bus_addr      <= {req_addr[ADDR_W-1:3], 3'b000};
                     bus_wstrb     <= strb_c;
                     bus_wdata     <= wdata_lanes;
                  end
               end
            end
            S_REQ: begin
               if (bus_req_ready) begin
                  bus_req_valid <= 1'b0;
                  cnt           <= '0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus_rsp_valid) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= bus_rsp_err;
                  resp_rdata <= (bus_rsp_err || bus_we) ? 64'h0 : load_c;
               end else if (TO_EN && (cnt == TO_LAST)) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 64'h0;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 4-cycle bus timeout.
module tb_lsu_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_rd_ctrl;
   logic [2:0]  req_wr_ctrl;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [7:0]  bus_wstrb;
   logic [63:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [63:0] bus_rsp_rdata;
   logic        bus_rsp_err;

   int total = 0;
   int bad   = 0;

   lsu_mem_ctrl #(.ADDR_W(64), .TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rd_ctrl   (req_rd_ctrl),
      .req_wr_ctrl   (req_wr_ctrl),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wstrb     (bus_wstrb),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; returns one cycle after acceptance.
   task automatic issue(input logic [2:0] rd, input logic [2:0] wr,
                        input logic [63:0] addr, input logic [63:0] wd);
      req_valid   = 1'b1;
      req_rd_ctrl = rd;
      req_wr_ctrl = wr;
      req_addr    = addr;
      req_wdata   = wd;
      step();
      req_valid   = 1'b0;
      req_rd_ctrl = 3'b000;
      req_wr_ctrl = 3'b000;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_rd_ctrl = 3'b000; req_wr_ctrl = 3'b000;
      req_addr = 64'h0; req_wdata = 64'h0; bus_req_ready = 1'b1;
      bus_rsp_valid = 1'b0; bus_rsp_rdata = 64'h0; bus_rsp_err = 1'b0;
      step();
      chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
      chk("rst_bus_valid", {63'h0, bus_req_valid}, 64'h0);
      chk("rst_ready", {63'h0, req_ready}, 64'h1);
      chk("rst_bus_addr", bus_addr, 64'h0);
      chk("rst_rdata", resp_rdata, 64'h0);
      step();
      rst_n = 1'b1;
      step();

      // lb / lbu, zero-wait bus
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h0000_0000_8000_0000;
      issue(3'b001, 3'b000, 64'h1003, 64'h0);
      chk("lb_bus_valid", {63'h0, bus_req_valid}, 64'h1);
      chk("lb_bus_addr", bus_addr, 64'h1000);
      chk("lb_wstrb", {56'h0, bus_wstrb}, 64'h08);
      chk("lb_we", {63'h0, bus_we}, 64'h0);
      chk("lb_ready_busy", {63'h0, req_ready}, 64'h0);
      step();
      chk("lb_c2_bus_valid", {63'h0, bus_req_valid}, 64'h0);
      chk("lb_c2_resp", {63'h0, resp_valid}, 64'h0);
      step();
      chk("lb_c3_resp", {63'h0, resp_valid}, 64'h1);
      chk("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_err", {63'h0, resp_err}, 64'h0);
      step();
      chk("lb_pulse", {63'h0, resp_valid}, 64'h0);
      chk("lb_ready_again", {63'h0, req_ready}, 64'h1);
      issue(3'b010, 3'b000, 64'h1003, 64'h0);
      step(); step();
      chk("lbu_resp", {63'h0, resp_valid}, 64'h1);
      chk("lbu_rdata", resp_rdata, 64'h80);
      step();

      // sh at offset 6
      issue(3'b000, 3'b010, 64'h2006, 64'h1234_ABCD);
      chk("sh_bus_addr", bus_addr, 64'h2000);
      chk("sh_we", {63'h0, bus_we}, 64'h1);
      chk("sh_wstrb", {56'h0, bus_wstrb}, 64'hC0);
      chk("sh_wdata", bus_wdata, 64'hABCD_0000_0000_0000);
      step(); step();
      chk("sh_resp", {63'h0, resp_valid}, 64'h1);
      chk("sh_rdata", resp_rdata, 64'h0);
      chk("sh_err", {63'h0, resp_err}, 64'h0);
      step();

      // local faults and no-op
      bus_rsp_valid = 1'b0;
      issue(3'b101, 3'b000, 64'h1002, 64'h0);
      chk("misal_resp", {63'h0, resp_valid}, 64'h1);
      chk("misal_err", {63'h0, resp_err}, 64'h1);
      chk("misal_no_bus", {63'h0, bus_req_valid}, 64'h0);
      step();
      chk("misal_pulse", {63'h0, resp_valid}, 64'h0);
      issue(3'b101, 3'b011, 64'h1000, 64'h0);
      chk("both_resp", {63'h0, resp_valid}, 64'h1);
      chk("both_err", {63'h0, resp_err}, 64'h1);
      chk("both_no_bus", {63'h0, bus_req_valid}, 64'h0);
      step();
      issue(3'b000, 3'b101, 64'h0, 64'h0);
      chk("illwr_err", {63'h0, resp_err}, 64'h1);
      step();
      issue(3'b000, 3'b000, 64'h0, 64'h0);
      chk("noop_resp", {63'h0, resp_valid}, 64'h1);
      chk("noop_err", {63'h0, resp_err}, 64'h0);
      chk("noop_rdata", resp_rdata, 64'h0);
      step();

      // ld with bus back-pressure; early response must be ignored
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h0123_4567_89AB_CDEF;
      issue(3'b110, 3'b000, 64'h3000, 64'h0);
      for (int i = 0; i < 4; i++) begin
         chk("ld_hold_valid", {63'h0, bus_req_valid}, 64'h1);
         chk("ld_hold_addr", bus_addr, 64'h3000);
         chk("ld_hold_wstrb", {56'h0, bus_wstrb}, 64'hFF);
         chk("ld_hold_noresp", {63'h0, resp_valid}, 64'h0);
         if (i == 3) bus_req_ready = 1'b1;
         step();
      end
      chk("ld_wait_valid", {63'h0, bus_req_valid}, 64'h0);
      step();
      chk("ld_resp", {63'h0, resp_valid}, 64'h1);
      chk("ld_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      step();
      bus_rsp_err = 1'b1;
      issue(3'b110, 3'b000, 64'h3000, 64'h0);
      step(); step();
      chk("lderr_resp", {63'h0, resp_valid}, 64'h1);
      chk("lderr_err", {63'h0, resp_err}, 64'h1);
      chk("lderr_rdata", resp_rdata, 64'h0);
      step();
      bus_rsp_err = 1'b0;

      // timeout after 4 WAIT cycles
      bus_rsp_valid = 1'b0;
      issue(3'b101, 3'b000, 64'h4000, 64'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("to_waiting", {63'h0, resp_valid}, 64'h0);
      end
      step();
      chk("to_resp", {63'h0, resp_valid}, 64'h1);
      chk("to_err", {63'h0, resp_err}, 64'h1);
      step();
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h0000_0000_BEEF_0000;
      issue(3'b011, 3'b000, 64'h4002, 64'h0);
      step(); step();
      chk("lh_resp", {63'h0, resp_valid}, 64'h1);
      chk("lh_err", {63'h0, resp_err}, 64'h0);
      chk("lh_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
      step();
      bus_rsp_rdata = 64'h8765_4321_0000_0000;
      issue(3'b101, 3'b000, 64'h5004, 64'h0);
      step(); step();
      chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
      step();

      // reset in WAIT, then a stale response
      bus_rsp_valid = 1'b0;
      issue(3'b000, 3'b100, 64'h6000, 64'hDEAD_BEEF_0000_1111);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mrst_bus_valid", {63'h0, bus_req_valid}, 64'h0);
      chk("mrst_we", {63'h0, bus_we}, 64'h0);
      chk("mrst_addr", bus_addr, 64'h0);
      chk("mrst_wstrb", {56'h0, bus_wstrb}, 64'h0);
      chk("mrst_wdata", bus_wdata, 64'h0);
      chk("mrst_ready", {63'h0, req_ready}, 64'h1);
      chk("mrst_rdata", resp_rdata, 64'h0);
      bus_rsp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stale_rsp", {63'h0, resp_valid}, 64'h0);
      end
      bus_rsp_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that consumes the decoder's memory-control codes (dm_rd_ctrl / dm_wr_ctrl) and executes them against a 64-bit data bus.
- Performs byte-lane alignment, write-strobe generation, load sign/zero extension, misalignment checks and bus timeout.
- Sits in the MEM stage. The pipeline stalls from request acceptance until resp_valid.

Parameters:
- ADDR_W, 64, width of the address on the core and bus sides.
- TIMEOUT_CYCLES, 255, maximum number of cycles spent waiting in WAIT for bus_rsp_valid; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_rd_ctrl  in  3  load code: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 ld, 111 illegal.
- req_wr_ctrl  in  3  store code: 000 none, 001 sb, 010 sh, 011 sw, 100 sd, 101-111 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load result; 0 for stores and errors.
- resp_err  out  1  access fault, valid with resp_valid.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts the request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  8-byte-aligned address (req_addr with bits [2:0] cleared).
- bus_wstrb  out  8  byte enables.
- bus_wdata  out  64  lane-shifted store data.
- bus_rsp_valid  in  1  bus response valid.
- bus_rsp_rdata  in  64  bus read data.
- bus_rsp_err  in  1  bus error.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state becomes IDLE.
  - resp_valid, resp_err, bus_req_valid, bus_we are 0; resp_rdata, bus_addr, bus_wstrb, bus_wdata are 0; timeout counter is 0.
  - Reset asserted mid-transaction drops the transaction. A bus_rsp_valid arriving later in IDLE is ignored.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready. All request fields are registered on acceptance.
- Access size: lb/lbu/sb = 1 byte, lh/lhu/sh = 2, lw/sw = 4, ld/sd = 8.
- Offset: off = req_addr[2:0].
- Misaligned accesses fault: half with off[0] != 0, word with off[1:0] != 0, dword with off != 0.
- Accepted request classification:
  - Fault, no bus traffic, next state RESP: misaligned access, rd and wr codes both nonzero, or an illegal code.
  - No-op, next state RESP with err = 0 and rdata = 0: both codes 000.
  - Otherwise next state REQ.
- FSM states: IDLE, REQ, WAIT, RESP.
  - REQ:
    - bus_req_valid = 1.
    - bus_we = (wr code != 0).
    - bus_wstrb = size mask << off; reads also drive the size mask.
    - bus_wdata = req_wdata << (8*off).
    - All bus_* outputs are held stable until bus_req_ready. On bus_req_valid && bus_req_ready, go to WAIT next cycle and deassert bus_req_valid.
  - WAIT:
    - Counter increments each cycle.
    - On bus_rsp_valid: capture the response and go to RESP.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without bus_rsp_valid: go to RESP with err = 1.
  - RESP:
    - resp_valid = 1 for exactly one cycle, then IDLE. req_ready stays 0 during RESP, so back-to-back requests are one cycle apart.
- Load result:
  - Extract byte/half/word at lane off from bus_rsp_rdata.
  - lb/lh/lw sign-extend to 64 bits; lbu/lhu zero-extend; ld passes through.
- Error results:
  - bus_rsp_err = 1 gives resp_err = 1, rdata = 0.
  - Stores always give rdata = 0.
- Latency:
  - Zero-wait bus (bus_req_ready = 1 in REQ, bus_rsp_valid = 1 in the first WAIT cycle): accept at cycle 0, REQ at 1, WAIT at 2, resp_valid at cycle 3.
  - Fault/no-op: resp_valid at cycle 1.
- bus_rsp_valid outside WAIT is ignored. Req_* inputs outside IDLE are ignored.

Test Plan:
1. lb at addr 0x1003, bus_rsp_rdata = 0x0000_0000_8000_0000, zero-wait bus -> bus_addr 0x1000, bus_wstrb 0x08, bus_we 0; resp_valid at cycle 3, resp_rdata 0xFFFF_FFFF_FFFF_FF80, resp_err 0. Same access as lbu -> resp_rdata 0x80.
2. sh addr 0x2006, wdata 0x1234_ABCD -> bus_addr 0x2000, bus_we 1, bus_wstrb 0xC0, bus_wdata[63:48] 0xABCD; resp_rdata 0, resp_err 0.
3. lw addr 0x1002 -> no bus_req_valid ever; resp_valid with resp_err 1 at cycle 1. Also rd 101 + wr 011 together -> same fault.
4. ld addr 0x3000 with bus_req_ready low for 3 cycles -> bus_req_valid, bus_addr, bus_wstrb 0xFF stable for 4 cycles; rdata 0x0123_4567_89AB_CDEF returned unchanged; bus_rsp_err 1 variant -> resp_err 1, rdata 0.
5. TIMEOUT_CYCLES = 4, bus never responds -> resp_valid with resp_err 1 exactly after 4 WAIT cycles; then a new request is accepted normally.
6. rst_n low for one cycle while in WAIT -> IDLE, all outputs 0; a subsequent stale bus_rsp_valid produces no resp_valid.
